// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and port identifiers for the writeback arbiter
package regfile_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  localparam logic PORT_LOAD = 1'b0;
  localparam logic PORT_ALU  = 1'b1;
endpackage

// File: rtl/wb_slot.sv
// rtl/wb_slot.sv - one-entry writeback holding slot with valid/ready handshake
module wb_slot
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              ready,
  output logic              capture,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // A granted slot drains on the same edge it refills, so one transfer per cycle is sustainable.
  assign ready   = !reset && (!valid || grant);
  assign capture = in_valid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      addr  <= in_addr;
      data  <= in_data;
    end else if (grant) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register file write port between load and ALU writeback
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  output logic                regWrite,
  output logic [ADDR_W-1:0]   writeReg,
  output logic [DATA_W-1:0]   writeData,
  output logic [NUM_REGS-1:0] pending,
  output logic                last_grant
);

  logic              slot0_valid, slot1_valid;
  logic [ADDR_W-1:0] slot0_addr, slot1_addr;
  logic [DATA_W-1:0] slot0_data, slot1_data;
  logic              grant0, grant1;
  logic              cap0, cap1;
  logic              older0;

  wb_slot u_slot0 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (req0_valid),
    .in_addr  (req0_addr),
    .in_data  (req0_data),
    .grant    (grant0),
    .ready    (req0_ready),
    .capture  (cap0),
    .valid    (slot0_valid),
    .addr     (slot0_addr),
    .data     (slot0_data)
  );

  wb_slot u_slot1 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (req1_valid),
    .in_addr  (req1_addr),
    .in_data  (req1_data),
    .grant    (grant1),
    .ready    (req1_ready),
    .capture  (cap1),
    .valid    (slot1_valid),
    .addr     (slot1_addr),
    .data     (slot1_data)
  );

  // Same destination must retire in arrival order; otherwise alternate.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (slot0_valid && slot1_valid) begin
      if (slot0_addr == slot1_addr) begin
        grant0 = older0;
        grant1 = !older0;
      end else begin
        grant0 = (last_grant == PORT_ALU);
        grant1 = (last_grant == PORT_LOAD);
      end
    end else begin
      grant0 = slot0_valid;
      grant1 = slot1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      older0 <= 1'b1;
    end else if (cap0 && cap1) begin
      older0 <= 1'b1;
    end else if (cap0 && slot1_valid && !grant1) begin
      older0 <= 1'b0;
    end else if (cap1 && slot0_valid && !grant0) begin
      older0 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite   <= 1'b0;
      writeReg   <= '0;
      writeData  <= '0;
      last_grant <= PORT_ALU;
    end else if (grant0 || grant1) begin
      regWrite   <= 1'b1;
      writeReg   <= grant0 ? slot0_addr : slot1_addr;
      writeData  <= grant0 ? slot0_data : slot1_data;
      last_grant <= grant0 ? PORT_LOAD : PORT_ALU;
    end else begin
      regWrite   <= 1'b0;
    end
  end

  always_comb begin
    pending = '0;
    if (slot0_valid) pending[slot0_addr] = 1'b1;
    if (slot1_valid) pending[slot1_addr] = 1'b1;
    if (regWrite)    pending[writeReg]   = 1'b1;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        regWrite;
  logic [3:0]  writeReg;
  logic [15:0] writeData;
  logic [15:0] pending;
  logic        last_grant;

  regfile_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .regWrite   (regWrite),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .pending    (pending),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    bit          port;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: each held request carries an arrival sequence number.
  bit          held[2];
  logic [3:0]  maddr[2];
  logic [15:0] mdata[2];
  int          mseq[2];
  int          next_seq = 0;
  int          mlast = 1;
  bit          lw_valid = 0;
  logic [3:0]  lw_addr = 0;

  bit          ov[2];
  logic [3:0]  oa[2];
  logic [15:0] od[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (regWrite !== 1'b1 || writeReg !== e.addr || writeData !== e.data || last_grant !== e.port) begin
        errors++;
        $display("FAIL write actual=%b/%0h/%0h/%b required=1/%0h/%0h/%b cycle=%0d",
                 regWrite, writeReg, writeData, last_grant, e.addr, e.data, e.port, cyc);
      end
    end else if (regWrite === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write actual=%0h/%0h required=none cycle=%0d", writeReg, writeData, cyc);
    end
  end

  function automatic int mgrant();
    if (held[0] && held[1]) begin
      if (maddr[0] == maddr[1]) return (mseq[0] < mseq[1]) ? 0 : 1;
      return (mlast == 1) ? 0 : 1;
    end
    if (held[0]) return 0;
    if (held[1]) return 1;
    return -1;
  endfunction

  function automatic logic [15:0] mpending();
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 2; i++) if (held[i]) p[maddr[i]] = 1'b1;
    if (lw_valid) p[lw_addr] = 1'b1;
    return p;
  endfunction

  // Drives one cycle from a negedge, checks handshake state, advances the model over the next edge.
  task automatic step(input bit rst,
                      input bit v0, input logic [3:0] a0, input logic [15:0] d0,
                      input bit v1, input logic [3:0] a1, input logic [15:0] d1,
                      output bit acc0, output bit acc1);
    int  g;
    bit  r0, r1;
    reset = rst;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    g  = mgrant();
    r0 = !rst && (!held[0] || g == 0);
    r1 = !rst && (!held[1] || g == 1);
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, r0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, r1});
    chk("pending", {16'b0, pending}, {16'b0, mpending()});
    acc0 = v0 && r0;
    acc1 = v1 && r1;
    if (rst) begin
      held[0] = 0; held[1] = 0;
      mlast = 1; lw_valid = 0;
    end else begin
      if (g >= 0) begin
        sb.push_back('{addr: maddr[g], data: mdata[g], port: (g == 1), cyc: cyc + 1});
        held[g] = 0; mlast = g; lw_valid = 1; lw_addr = maddr[g];
      end else begin
        lw_valid = 0;
      end
      if (acc0) begin held[0] = 1; maddr[0] = a0; mdata[0] = d0; mseq[0] = next_seq++; end
      if (acc1) begin held[1] = 1; maddr[1] = a1; mdata[1] = d1; mseq[1] = next_seq++; end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit x0, x1;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, x0, x1);
  endtask

  // Offers persist until accepted, like a real producer.
  task automatic run_phase(input int n, input int p0, input int p1,
                           input logic [3:0] base0, input logic [3:0] base1, input logic [3:0] mask);
    bit a0, a1;
    ov[0] = 0; ov[1] = 0;
    for (int i = 0; i < n; i++) begin
      if (!ov[0]) begin
        ov[0] = ($urandom_range(0, 99) < p0);
        oa[0] = base0 + (4'($urandom) & mask);
        od[0] = 16'($urandom);
      end
      if (!ov[1]) begin
        ov[1] = ($urandom_range(0, 99) < p1);
        oa[1] = base1 + (4'($urandom) & mask);
        od[1] = 16'($urandom);
      end
      step(0, ov[0], oa[0], od[0], ov[1], oa[1], od[1], a0, a1);
      if (a0) ov[0] = 0;
      if (a1) ov[1] = 0;
    end
  endtask

  initial begin
    bit a0, a1;
    int guard;
    held[0] = 0; held[1] = 0;
    reset = 1;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, a0, a1);
    step(1, 0, 0, 0, 0, 0, 0, a0, a1);

    chk("reset_regWrite",   {31'b0, regWrite},   32'd0);
    chk("reset_writeReg",   {28'b0, writeReg},   32'd0);
    chk("reset_writeData",  {16'b0, writeData},  32'd0);
    chk("reset_last_grant", {31'b0, last_grant}, 32'd1);
    chk("reset_pending",    {16'b0, pending},    32'd0);

    // Single ALU write to r5.
    step(0, 0, 0, 0, 1, 4'd5, 16'h1234, a0, a1);
    chk("single_accept", {31'b0, a1}, 32'd1);
    idle(4);

    // Both ports stream to distinct registers.
    run_phase(12, 100, 100, 4'd2, 4'd3, 4'd0);
    idle(4);

    // Same register from ALU then load.
    step(0, 0, 0, 0, 1, 4'd7, 16'hAAAA, a0, a1);
    step(0, 1, 4'd7, 16'hBBBB, 0, 0, 0, a0, a1);
    idle(4);

    // Simultaneous capture of r9 with last_grant pointing at the load port.
    step(0, 1, 4'd4, 16'h0404, 0, 0, 0, a0, a1);
    idle(3);
    step(0, 1, 4'd9, 16'h9000, 1, 4'd9, 16'h9001, a0, a1);
    idle(4);

    // Reset one cycle after two requests are accepted.
    step(0, 1, 4'd10, 16'h1010, 1, 4'd11, 16'h1111, a0, a1);
    step(1, 0, 0, 0, 0, 0, 0, a0, a1);
    chk("post_reset_pending", {16'b0, pending}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, a0, a1);
    idle(2);

    // Load port streaming alone.
    run_phase(10, 100, 0, 4'd0, 4'd0, 4'hF);
    idle(3);

    // Random traffic, narrow address range to provoke same-register ordering.
    run_phase(300, 70, 70, 4'd0, 4'd0, 4'd1);
    run_phase(300, 60, 80, 4'd0, 4'd0, 4'hF);
    // Random reset hits.
    for (int k = 0; k < 5; k++) begin
      run_phase(20, 80, 80, 4'd0, 4'd0, 4'd3);
      step(1, 1, 4'd1, 16'hFFFF, 1, 4'd1, 16'hEEEE, a0, a1);
    end
    idle(4);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d outstanding required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
